// File: rtl/hotspot_pkg.sv
// rtl/hotspot_pkg.sv - shared FSM states, screen/grid defaults and overlay sprite geometry
package hotspot_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, CALC, WAIT_VS} state_t;

  localparam int GRID_W_DEF = 16;
  localparam int GRID_H_DEF = 9;
  localparam int PWR_W_DEF  = 24;
  localparam int CELL_W_DEF = 30;
  localparam int CELL_H_DEF = 30;
  localparam int SCR_W_DEF  = 480;
  localparam int SCR_H_DEF  = 272;

  // Sprite size is shared with the overlay renderer.
  localparam int THD_SIZE = 49;
  localparam int THD_HALF = (THD_SIZE - 1) / 2;

  function automatic logic [15:0] clamp16(input logic [15:0] v,
                                          input logic [15:0] lo,
                                          input logic [15:0] hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

endpackage

// File: rtl/hotspot_coord_map.sv
// rtl/hotspot_coord_map.sv - two-stage grid cell to clamped screen pixel centre map
module hotspot_coord_map #(
  parameter int COL_W    = 4,
  parameter int ROW_W    = 4,
  parameter int CELL_W   = hotspot_pkg::CELL_W_DEF,
  parameter int CELL_H   = hotspot_pkg::CELL_H_DEF,
  parameter int SCR_W    = hotspot_pkg::SCR_W_DEF,
  parameter int SCR_H    = hotspot_pkg::SCR_H_DEF,
  parameter int THD_HALF = hotspot_pkg::THD_HALF
) (
  input  logic             clk_pix,
  input  logic             rst,
  input  logic             start,
  input  logic [COL_W-1:0] col,
  input  logic [ROW_W-1:0] row,
  output logic [15:0]      x,
  output logic [15:0]      y
);
  import hotspot_pkg::*;

  localparam logic [15:0] X_LO = 16'(THD_HALF);
  localparam logic [15:0] X_HI = 16'(SCR_W - 1 - THD_HALF);
  localparam logic [15:0] Y_LO = 16'(THD_HALF);
  localparam logic [15:0] Y_HI = 16'(SCR_H - 1 - THD_HALF);

  logic [15:0] cx, cy;
  logic        stage2;

  // x/y hold the clamped result until the next start, so they act as the shadow.
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      cx     <= '0;
      cy     <= '0;
      stage2 <= 1'b0;
      x      <= 16'(SCR_W / 2);
      y      <= 16'(SCR_H / 2);
    end else begin
      stage2 <= start;
      if (start) begin
        cx <= 16'(col) * 16'(CELL_W) + 16'(CELL_W / 2);
        cy <= 16'(row) * 16'(CELL_H) + 16'(CELL_H / 2);
      end
      if (stage2) begin
        x <= clamp16(cx, X_LO, X_HI);
        y <= clamp16(cy, Y_LO, Y_HI);
      end
    end
  end

endmodule

// File: rtl/hotspot_locate.sv
// rtl/hotspot_locate.sv - peak cell search over a power grid, committed on display VS
// Optional HOTSPOT_THRESH_EN adds pwr_thd/hot_en gating of coordinate updates.
module hotspot_locate #(
  parameter int GRID_W   = hotspot_pkg::GRID_W_DEF,
  parameter int GRID_H   = hotspot_pkg::GRID_H_DEF,
  parameter int PWR_W    = hotspot_pkg::PWR_W_DEF,
  parameter int CELL_W   = hotspot_pkg::CELL_W_DEF,
  parameter int CELL_H   = hotspot_pkg::CELL_H_DEF,
  parameter int SCR_W    = hotspot_pkg::SCR_W_DEF,
  parameter int SCR_H    = hotspot_pkg::SCR_H_DEF,
  parameter int THD_HALF = hotspot_pkg::THD_HALF
) (
  input  logic             clk_pix,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PWR_W-1:0] s_data,
  input  logic             s_sof,
  input  logic             vs_in,
`ifdef HOTSPOT_THRESH_EN
  input  logic [PWR_W-1:0] pwr_thd,
  output logic             hot_en,
`endif
  output logic [15:0]      pix_x,
  output logic [15:0]      pix_y,
  output logic [PWR_W-1:0] peak_pwr,
  output logic             loc_valid,
  output logic             frame_err
);
  import hotspot_pkg::*;

  localparam int COL_W = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int ROW_W = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(GRID_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(GRID_H - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'((GRID_W == 1) ? 0 : 1);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'((GRID_W == 1) ? 1 : 0);
  localparam bit               ONE_CELL  = (GRID_W * GRID_H == 1);

  state_t             state, next_state;
  logic [COL_W-1:0]   col, best_col;
  logic [ROW_W-1:0]   row, best_row;
  logic [PWR_W-1:0]   best, shadow_pwr;
  logic               calc_cnt, vs_r;
  logic               xfer, vs_rise, last_idx;
  logic               frame_start, accept, abort, calc_start, commit;
  logic [15:0]        map_x, map_y;

  assign xfer     = s_valid && s_ready;
  assign vs_rise  = vs_in && !vs_r;
  assign last_idx = (col == COL_LAST) && (row == ROW_LAST);

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = state;
    s_ready     = 1'b0;
    frame_start = 1'b0;
    accept      = 1'b0;
    abort       = 1'b0;
    calc_start  = 1'b0;
    commit      = 1'b0;
    case (state)
      IDLE: begin
        s_ready = 1'b1;
        if (xfer && s_sof) begin
          frame_start = 1'b1;
          next_state  = ONE_CELL ? CALC : ACCUM;
        end
      end
      ACCUM: begin
        s_ready = 1'b1;
        if (xfer) begin
          if (s_sof) begin
            frame_start = 1'b1;
            abort       = 1'b1;
            next_state  = ONE_CELL ? CALC : ACCUM;
          end else begin
            accept = 1'b1;
            if (last_idx) next_state = CALC;
          end
        end
      end
      CALC: begin
        calc_start = !calc_cnt;
        if (calc_cnt) next_state = WAIT_VS;
      end
      WAIT_VS: begin
        if (vs_rise) begin
          commit     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  hotspot_coord_map #(
    .COL_W(COL_W), .ROW_W(ROW_W), .CELL_W(CELL_W), .CELL_H(CELL_H),
    .SCR_W(SCR_W), .SCR_H(SCR_H), .THD_HALF(THD_HALF)
  ) u_coord_map (
    .clk_pix (clk_pix),
    .rst     (rst),
    .start   (calc_start),
    .col     (best_col),
    .row     (best_row),
    .x       (map_x),
    .y       (map_y)
  );

`ifdef HOTSPOT_THRESH_EN
  logic hot;
  assign hot = (shadow_pwr >= pwr_thd);
`endif

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      best       <= '0;
      best_col   <= '0;
      best_row   <= '0;
      calc_cnt   <= 1'b0;
      vs_r       <= 1'b0;
      shadow_pwr <= '0;
      pix_x      <= 16'(SCR_W / 2);
      pix_y      <= 16'(SCR_H / 2);
      peak_pwr   <= '0;
      loc_valid  <= 1'b0;
      frame_err  <= 1'b0;
`ifdef HOTSPOT_THRESH_EN
      hot_en     <= 1'b0;
`endif
    end else begin
      vs_r      <= vs_in;
      loc_valid <= commit;
      frame_err <= abort;
      calc_cnt  <= (state == CALC) && !calc_cnt;

      if (frame_start) begin
        best     <= s_data;
        best_col <= '0;
        best_row <= '0;
        col      <= COL_FIRST;
        row      <= ROW_FIRST;
      end else if (accept) begin
        // Strictly greater: ties keep the earliest cell in raster order.
        if (s_data > best) begin
          best     <= s_data;
          best_col <= col;
          best_row <= row;
        end
        if (col == COL_LAST) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      if (state == CALC && calc_cnt) shadow_pwr <= best;

      if (commit) begin
        peak_pwr <= shadow_pwr;
`ifdef HOTSPOT_THRESH_EN
        hot_en <= hot;
        if (hot) begin
          pix_x <= map_x;
          pix_y <= map_y;
        end
`else
        pix_x <= map_x;
        pix_y <= map_y;
`endif
      end
    end
  end

endmodule

// File: tb/tb_hotspot_locate.sv
// tb/tb_hotspot_locate.sv - randomized scoreboard bench for hotspot_locate (default build)
module tb_hotspot_locate;

  localparam int GW = 16;
  localparam int GH = 9;
  localparam int N  = GW * GH;

  logic        clk_pix = 1'b0;
  logic        rst, s_valid, s_ready, s_sof, vs_in, loc_valid, frame_err;
  logic [23:0] s_data, peak_pwr;
  logic [15:0] pix_x, pix_y;

  always #5 clk_pix = ~clk_pix;

  hotspot_locate dut (
    .clk_pix   (clk_pix),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_sof     (s_sof),
    .vs_in     (vs_in),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .peak_pwr  (peak_pwr),
    .loc_valid (loc_valid),
    .frame_err (frame_err)
  );

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [23:0] p;
  } want_t;

  want_t       exp_q[$];
  want_t       mon_w;
  logic [23:0] frm[$];
  int          n_cmp = 0, n_fail = 0, n_err_seen = 0, n_loc = 0;
  bit          vs_rand = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: earliest maximum in raster order, cell centre, clamp to keep the sprite on screen.
  function automatic want_t model();
    int    bi = 0;
    int    cx, cy;
    want_t w;
    for (int i = 1; i < frm.size(); i++)
      if (frm[i] > frm[bi]) bi = i;
    cx = (bi % GW) * 30 + 15;
    cy = (bi / GW) * 30 + 15;
    cx = (cx < 24) ? 24 : ((cx > 455) ? 455 : cx);
    cy = (cy < 24) ? 24 : ((cy > 247) ? 247 : cy);
    w.x = 16'(cx);
    w.y = 16'(cy);
    w.p = frm[bi];
    return w;
  endfunction

  always @(negedge clk_pix) begin
    if (rst === 1'b0) begin
      if (frame_err) n_err_seen++;
      if (loc_valid) begin
        n_loc++;
        check("loc_valid_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          mon_w = exp_q.pop_front();
          check("pix_x", 64'(pix_x), 64'(mon_w.x));
          check("pix_y", 64'(pix_y), 64'(mon_w.y));
          check("peak_pwr", 64'(peak_pwr), 64'(mon_w.p));
        end
      end
    end
  end

  task automatic send_sample(input logic [23:0] d, input logic sof);
    int guard = 0;
    if ($urandom_range(0, 3) == 0) begin
      s_valid = 1'b0;
      s_data  = 24'($urandom);
      s_sof   = 1'($urandom_range(0, 1));
      if (vs_rand) vs_in = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 3)) @(posedge clk_pix);
      #1;
    end
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    @(negedge clk_pix);
    while (!s_ready && guard < 200) begin
      @(negedge clk_pix);
      guard++;
    end
    if (guard >= 200) check("s_ready_timeout", 64'(s_ready), 64'd1);
    @(posedge clk_pix);
    #1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic send_part(input int lo, input int hi);
    for (int i = lo; i < hi; i++) send_sample(frm[i], i == 0);
    vs_in = 1'b0;
  endtask

  task automatic fill_rand(input int unsigned maxv);
    frm.delete();
    for (int i = 0; i < N; i++) frm.push_back(24'($urandom_range(0, maxv)));
  endtask

  task automatic fill_const(input logic [23:0] v);
    frm.delete();
    for (int i = 0; i < N; i++) frm.push_back(v);
  endtask

  task automatic wait_drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 50) begin
      @(posedge clk_pix);
      g++;
    end
    #1;
    if (exp_q.size() != 0) begin
      check("commit_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  task automatic pulse_vs();
    vs_in = 1'b1;
    repeat (2) @(posedge clk_pix);
    #1;
    vs_in = 1'b0;
  endtask

  task automatic commit_frame();
    vs_in = 1'b0;
    repeat (4) @(posedge clk_pix);
    #1;
    exp_q.push_back(model());
    pulse_vs();
    wait_drain();
  endtask

  initial begin
    int err_before, loc_before;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_sof = 1'b0; vs_in = 1'b0;
    repeat (3) @(posedge clk_pix);
    #1;
    rst = 1'b0;

    check("rst_pix_x", 64'(pix_x), 64'd240);
    check("rst_pix_y", 64'(pix_y), 64'd136);
    check("rst_peak", 64'(peak_pwr), 64'd0);
    check("rst_loc_valid", 64'(loc_valid), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd1);

    // Samples without s_sof in IDLE are dropped.
    for (int i = 0; i < 5; i++) send_sample(24'hFFFFFF, 1'b0);

    vs_rand = 1'b1;
    fill_const(24'd100);
    frm[3 * GW + 5] = 24'd900;
    send_part(0, N);
    commit_frame();
    check("single_x", 64'(pix_x), 64'd165);
    check("single_y", 64'(pix_y), 64'd105);
    check("single_p", 64'(peak_pwr), 64'd900);

    fill_const(24'd0);
    frm[0] = 24'd500;
    frm[N - 1] = 24'd500;
    send_part(0, N);
    commit_frame();
    check("tie_x", 64'(pix_x), 64'd24);
    check("tie_y", 64'(pix_y), 64'd24);

    fill_rand(999);
    frm[N - 1] = 24'd1000;
    send_part(0, N);
    commit_frame();
    check("edge_x", 64'(pix_x), 64'd455);
    check("edge_y", 64'(pix_y), 64'd247);

    // Short frame: aborted frame carries a huge peak that must not leak.
    err_before = n_err_seen;
    fill_rand(5000);
    frm[10] = 24'd900000;
    send_part(0, 50);
    fill_rand(1000);
    send_part(0, N);
    check("short_frame_err", 64'(n_err_seen - err_before), 64'd1);
    commit_frame();

    // VS rises in ACCUM and on the shadow-load cycle; neither may commit.
    loc_before = n_loc;
    vs_rand = 1'b0;
    fill_rand(24'hFFFFFF);
    send_part(0, 70);
    pulse_vs();
    send_part(70, N);
    @(posedge clk_pix);
    #1;
    vs_in = 1'b1;
    repeat (3) @(posedge clk_pix);
    #1;
    vs_in = 1'b0;
    repeat (2) @(posedge clk_pix);
    #1;
    check("vs_gating_no_commit", 64'(n_loc - loc_before), 64'd0);
    commit_frame();

    for (int k = 0; k < 6; k++) begin
      fill_rand((k % 2) ? 15 : 32'hFFFFFF);
      if (k % 3 == 2) begin
        // Next frame's SOF is offered while the previous result waits for VS.
        vs_rand = 1'b0;
        send_part(0, N);
        repeat (4) @(posedge clk_pix);
        #1;
        exp_q.push_back(model());
        fill_rand(255);
        fork
          send_part(0, N);
          begin
            repeat (6) @(posedge clk_pix);
            #1;
            pulse_vs();
          end
        join
        wait_drain();
        commit_frame();
      end else begin
        vs_rand = 1'b1;
        send_part(0, N);
        commit_frame();
      end
    end

    // Asynchronous reset in the middle of ACCUM.
    vs_rand = 1'b0;
    fill_rand(24'hFFFFFF);
    send_part(0, 60);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_pix_x", 64'(pix_x), 64'd240);
    check("mid_rst_pix_y", 64'(pix_y), 64'd136);
    check("mid_rst_peak", 64'(peak_pwr), 64'd0);
    repeat (2) @(posedge clk_pix);
    #1;
    rst = 1'b0;
    fill_rand(24'hFFFFFF);
    send_part(0, N);
    commit_frame();

    check("frame_err_total", 64'(n_err_seen), 64'd1);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hotspot_locate.md
Name: hotspot_locate

Overview:
- Sink-side producer of the hotspot overlay coordinates. It consumes one frame of beamformed acoustic power samples, which arrive in raster order over a GRID_W x GRID_H steering grid.
- It finds the peak cell and converts the cell index to a screen pixel centre, clamped so the full overlay sprite stays on screen.
- It publishes pix_x/pix_y to the overlay renderer only on a display vertical-sync edge, so the sprite never tears mid-frame.

Parameters:
- GRID_W, 16, steering grid columns
- GRID_H, 9, steering grid rows
- PWR_W, 24, power sample width (unsigned)
- CELL_W, 30, screen pixels per grid column
- CELL_H, 30, screen pixels per grid row
- SCR_W, 480, active screen width
- SCR_H, 272, active screen height
- THD_HALF, 24, overlay sprite half-size, i.e. (49-1)/2

Ports:
- clk_pix  in  1  pixel clock; the only clock
- rst  in  1  asynchronous, active-high reset
- s_valid  in  1  power sample valid
- s_ready  out  1  block can accept a sample
- s_data  in  PWR_W  power sample, unsigned
- s_sof  in  1  marks the first sample of a grid frame; qualified by s_valid&&s_ready
- vs_in  in  1  display VS, active-high, synchronous to clk_pix
- pix_x  out  16  committed hotspot centre X
- pix_y  out  16  committed hotspot centre Y
- peak_pwr  out  PWR_W  committed peak power
- loc_valid  out  1  one-cycle pulse when pix_x/pix_y update
- frame_err  out  1  one-cycle pulse on a short or aborted frame

Behaviour:
- Reset values: pix_x=SCR_W/2, pix_y=SCR_H/2, peak_pwr=0, loc_valid=0, frame_err=0. The FSM enters IDLE.
- Reset mid-frame discards all partial results.
- Handshake: a sample transfers on a cycle where s_valid&&s_ready. s_ready is 1 only in IDLE and ACCUM.
- In IDLE, transfers without s_sof are dropped.
- FSM states:
  - IDLE: a transfer with s_sof loads best=s_data, best_col=0, best_row=0, col=1 (or col=0,row=1 if GRID_W==1), then goes to ACCUM.
  - ACCUM: each transfer advances col, which wraps at GRID_W-1 and increments row.
    - A sample replaces best only if it is strictly greater, so ties keep the earliest cell.
    - The transfer with index GRID_W*GRID_H-1 goes to CALC.
    - A transfer with s_sof before the frame is complete pulses frame_err, restarts the frame with that sample as index 0, and stays in ACCUM.
  - CALC (2 cycles):
    - Cycle 1: cx = best_col*CELL_W + CELL_W/2 and cy = best_row*CELL_H + CELL_H/2, computed at 16-bit width.
    - Cycle 2: clamp cx to [THD_HALF, SCR_W-1-THD_HALF] and cy to [THD_HALF, SCR_H-1-THD_HALF]; store into a shadow register; go to WAIT_VS.
  - WAIT_VS: on the vs_in rising edge (registered vs_in was 0, current is 1), copy shadow into pix_x/pix_y/peak_pwr, pulse loc_valid, and go to IDLE.
- VS edge detection runs continuously. An edge seen in any state other than WAIT_VS is ignored.
- Latency: from the last sample's transfer to shadow loaded is 3 cycles. Output update follows at the next VS rising edge after that.
- A VS edge on the same cycle as shadow load is not used; the commit waits for the next edge.
- s_sof in WAIT_VS is not accepted (s_ready=0). The upstream source holds it.

Optional Feature:
- Macro: HOTSPOT_THRESH_EN.
- When defined:
  - Adds input pwr_thd[PWR_W] and output hot_en[1] (reset 0).
  - At commit, hot_en <= (shadow peak >= pwr_thd).
  - If hot_en would be 0, pix_x/pix_y keep their previous values; peak_pwr and loc_valid still update.
- When undefined: no extra ports; every commit updates the coordinates.

Decomposition:
- Package hotspot_pkg holds:
  - FSM state enum (IDLE, ACCUM, CALC, WAIT_VS)
  - screen/grid default constants
  - THD_SIZE=49 and THD_HALF, shared with the overlay renderer
- One natural sub-module: hotspot_coord_map. It performs the registered cell-to-pixel multiply plus clamp (the 2-cycle CALC datapath).

Test Plan:
- Single peak: a 144-sample frame, all 100 except cell (col 5, row 3)=900, then a VS pulse -> pix_x=165, pix_y=105, peak_pwr=900, one loc_valid pulse.
- Tie and clamp: cells 0 and 143 both 500, rest 0 -> best is cell 0. Raw (15,15) clamps to pix_x=24, pix_y=24.
- Edge clamp: peak at (15,8) -> raw (465,255) clamps to pix_x=455, pix_y=247.
- Short frame: s_sof after 50 samples -> frame_err pulses once. The new frame completes normally and its peak is reported with no contamination from the aborted frame.
- VS gating: VS rises during ACCUM and again 2 cycles after the last sample -> no commit on either. Commit and loc_valid occur on the next VS rise only.
- Async reset asserted mid-ACCUM -> outputs return to (240,136,0); the following full frame reports correctly. With HOTSPOT_THRESH_EN and pwr_thd=1000, peak 900 -> hot_en=0 and coordinates are unchanged.
